// File: rtl/banked_ram_ctrl.sv
// True-dual-port RAM with byte enables, write-write collision stall, optional
// output register and a zero-fill sequencer that runs after every reset.
module banked_ram_ctrl #(
  parameter int unsigned WIDTHAD        = 16,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BYTES          = WIDTH / 8,
  parameter int unsigned OUTREG         = 0,
  parameter int unsigned MLAB           = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               busy_o,

  input  logic               a_req_i,
  input  logic               a_we_i,
  input  logic [BYTES-1:0]   a_be_i,
  input  logic [WIDTHAD-1:0] a_addr_i,
  input  logic [WIDTH-1:0]   a_wdata_i,
  output logic               a_ready_o,
  output logic               a_rvalid_o,
  output logic [WIDTH-1:0]   a_rdata_o,

  input  logic               b_req_i,
  input  logic               b_we_i,
  input  logic [BYTES-1:0]   b_be_i,
  input  logic [WIDTHAD-1:0] b_addr_i,
  input  logic [WIDTH-1:0]   b_wdata_i,
  output logic               b_ready_o,
  output logic               b_rvalid_o,
  output logic [WIDTH-1:0]   b_rdata_o
);

  localparam int unsigned Depth = 2 ** WIDTHAD;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e               state_q;
  logic [WIDTHAD-1:0]   clr_cnt_q;

  logic                 busy;
  logic                 collide;
  logic [1:0]           acc;
  logic [1:0]           rd_acc;
  logic [1:0]           wr_acc;
  logic [WIDTHAD-1:0]   addr      [2];
  logic [BYTES-1:0]     be        [2];
  logic [WIDTH-1:0]     wdata     [2];

  logic [1:0]           mem_we;
  logic [BYTES-1:0]     mem_be    [2];
  logic [WIDTHAD-1:0]   mem_waddr [2];
  logic [WIDTH-1:0]     mem_wdata [2];

  logic [1:0]           rd_vld_q;
  logic [WIDTH-1:0]     rd_data_q [2];
  logic [1:0]           pre_vld;
  logic [WIDTH-1:0]     pre_data  [2];
  logic [1:0]           out_vld_q;
  logic [WIDTH-1:0]     out_data_q [2];

  // Clear sequencer: one zero word per edge, leaves CLEAR on the last address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? StClear : StRun;
      clr_cnt_q <= '0;
    end else if (state_q == StClear) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
      if (clr_cnt_q == {WIDTHAD{1'b1}}) begin
        state_q <= StRun;
      end
    end
  end

  assign busy    = (state_q == StClear);
  assign busy_o  = busy;
  // Port A wins a same-address write-write; B stalls and commits later.
  assign collide = a_req_i & a_we_i & b_req_i & b_we_i & (a_addr_i == b_addr_i);

  assign a_ready_o = ~busy;
  assign b_ready_o = ~busy & ~collide;

  assign acc    = {b_req_i & b_ready_o, a_req_i & a_ready_o};
  assign rd_acc = acc & ~{b_we_i, a_we_i};
  assign wr_acc = acc & {b_we_i, a_we_i};

  assign addr[0]  = a_addr_i;
  assign addr[1]  = b_addr_i;
  assign be[0]    = a_be_i;
  assign be[1]    = b_be_i;
  assign wdata[0] = a_wdata_i;
  assign wdata[1] = b_wdata_i;

  // The clear sequencer borrows port A's write path while clients are held off.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      mem_we[p]    = wr_acc[p];
      mem_be[p]    = be[p];
      mem_waddr[p] = addr[p];
      mem_wdata[p] = wdata[p];
    end
    if (busy) begin
      mem_we[0]    = 1'b1;
      mem_be[0]    = '1;
      mem_waddr[0] = clr_cnt_q;
      mem_wdata[0] = '0;
    end
  end

  if (MLAB != 0) begin : g_mlab
    (* ramstyle = "MLAB" *) logic [WIDTH-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
      for (int p = 0; p < 2; p++) begin
        if (mem_we[p]) begin
          for (int i = 0; i < BYTES; i++) begin
            if (mem_be[p][i]) mem[mem_waddr[p]][8*i +: 8] <= mem_wdata[p][8*i +: 8];
          end
        end
        if (rd_acc[p]) rd_data_q[p] <= mem[addr[p]];
      end
    end
  end else begin : g_m10k
    (* ramstyle = "M10K" *) logic [WIDTH-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
      for (int p = 0; p < 2; p++) begin
        if (mem_we[p]) begin
          for (int i = 0; i < BYTES; i++) begin
            if (mem_be[p][i]) mem[mem_waddr[p]][8*i +: 8] <= mem_wdata[p][8*i +: 8];
          end
        end
        if (rd_acc[p]) rd_data_q[p] <= mem[addr[p]];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_vld_q <= '0;
    end else begin
      rd_vld_q <= rd_acc;
    end
  end

  if (OUTREG != 0) begin : g_outreg
    logic [1:0]       s2_vld_q;
    logic [WIDTH-1:0] s2_data_q [2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s2_vld_q     <= '0;
        s2_data_q[0] <= '0;
        s2_data_q[1] <= '0;
      end else begin
        s2_vld_q <= rd_vld_q;
        for (int p = 0; p < 2; p++) begin
          if (rd_vld_q[p]) s2_data_q[p] <= rd_data_q[p];
        end
      end
    end

    assign pre_vld     = s2_vld_q;
    assign pre_data[0] = s2_data_q[0];
    assign pre_data[1] = s2_data_q[1];
  end else begin : g_no_outreg
    assign pre_vld     = rd_vld_q;
    assign pre_data[0] = rd_data_q[0];
    assign pre_data[1] = rd_data_q[1];
  end

  // Output stage holds its data between valid pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld_q     <= '0;
      out_data_q[0] <= '0;
      out_data_q[1] <= '0;
    end else begin
      out_vld_q <= pre_vld;
      for (int p = 0; p < 2; p++) begin
        if (pre_vld[p]) out_data_q[p] <= pre_data[p];
      end
    end
  end

  assign a_rvalid_o = out_vld_q[0];
  assign b_rvalid_o = out_vld_q[1];
  assign a_rdata_o  = out_data_q[0];
  assign b_rdata_o  = out_data_q[1];

endmodule

// File: tb/tb_banked_ram_ctrl.sv
// Directed plus random bench for banked_ram_ctrl against an array/queue model.
module tb_banked_ram_ctrl;

  localparam int unsigned OUTREG = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic        a_req, a_we, b_req, b_we;
  logic [3:0]  a_be, b_be, a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic        a_ready, b_ready, a_rvalid, b_rvalid;

  banked_ram_ctrl #(
    .WIDTHAD        (4),
    .WIDTH          (32),
    .OUTREG         (OUTREG),
    .MLAB           (0),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .busy_o     (busy),
    .a_req_i    (a_req),
    .a_we_i     (a_we),
    .a_be_i     (a_be),
    .a_addr_i   (a_addr),
    .a_wdata_i  (a_wdata),
    .a_ready_o  (a_ready),
    .a_rvalid_o (a_rvalid),
    .a_rdata_o  (a_rdata),
    .b_req_i    (b_req),
    .b_we_i     (b_we),
    .b_be_i     (b_be),
    .b_addr_i   (b_addr),
    .b_wdata_i  (b_wdata),
    .b_ready_o  (b_ready),
    .b_rvalid_o (b_rvalid),
    .b_rdata_o  (b_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rd_t;

  logic [31:0] mdl [16];
  rd_t         qa[$];
  rd_t         qb[$];
  logic [31:0] last_a, last_b;
  int          clr_left;
  int          cyc;
  int          n_cmp;
  int          n_err;
  int          run_a, run_b;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] bm);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (bm[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  task automatic set_a(input logic rq, input logic w, input logic [3:0] bm,
                       input logic [3:0] ad, input logic [31:0] d);
    a_req = rq; a_we = w; a_be = bm; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic rq, input logic w, input logic [3:0] bm,
                       input logic [3:0] ad, input logic [31:0] d);
    b_req = rq; b_we = w; b_be = bm; b_addr = ad; b_wdata = d;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    set_b(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  // One clock: check readiness before the edge, update the model, check read returns after it.
  task automatic tick();
    logic busy_m, col, a_ok, b_ok, va, vb;
    #2;
    busy_m = (clr_left > 0);
    col    = a_req & a_we & b_req & b_we & (a_addr == b_addr);
    a_ok   = a_req & !busy_m;
    b_ok   = b_req & !busy_m & !col;
    chk1("busy", busy, busy_m);
    chk1("a_ready", a_ready, !busy_m);
    chk1("b_ready", b_ready, !busy_m && !col);
    if (a_ok && !a_we) qa.push_back('{due: cyc + 2 + int'(OUTREG), d: mdl[a_addr]});
    if (b_ok && !b_we) qb.push_back('{due: cyc + 2 + int'(OUTREG), d: mdl[b_addr]});
    if (busy_m) begin
      mdl[16 - clr_left] = 32'h0;
      clr_left--;
    end
    if (a_ok && a_we) mdl[a_addr] = merge(mdl[a_addr], a_wdata, a_be);
    if (b_ok && b_we) mdl[b_addr] = merge(mdl[b_addr], b_wdata, b_be);
    @(posedge clk);
    cyc++;
    #1;
    va = 1'b0;
    vb = 1'b0;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      va = 1'b1; last_a = qa[0].d; void'(qa.pop_front());
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      vb = 1'b1; last_b = qb[0].d; void'(qb.pop_front());
    end
    chk1("a_rvalid", a_rvalid, va);
    chk1("b_rvalid", b_rvalid, vb);
    chk32("a_rdata", a_rdata, last_a);
    chk32("b_rdata", b_rdata, last_b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    last_a   = 32'h0;
    last_b   = 32'h0;
    clr_left = 16;
    chk1("rst_busy", busy, 1'b1);
    chk1("rst_a_ready", a_ready, 1'b0);
    chk1("rst_b_ready", b_ready, 1'b0);
    chk1("rst_a_rvalid", a_rvalid, 1'b0);
    chk1("rst_b_rvalid", b_rvalid, 1'b0);
    chk32("rst_a_rdata", a_rdata, 32'h0);
    chk32("rst_b_rdata", b_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    rst_n = 1'b1;
    idle();
    #1;
    do_reset();

    // Clear window, then every word reads back zero on both ports.
    repeat (17) tick();
    for (int i = 0; i < 16; i++) begin
      set_a(1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
      set_b(1'b1, 1'b0, 4'h0, 4'(15 - i), 32'h0);
      tick();
    end
    idle();
    repeat (2 + OUTREG) tick();
    chk32("t1_zero_a", a_rdata, 32'h0);
    chk32("t1_zero_b", b_rdata, 32'h0);

    // Partial-word write merge.
    set_a(1'b1, 1'b1, 4'hF, 4'd3, 32'hAABBCCDD); tick();
    set_a(1'b1, 1'b1, 4'b0101, 4'd3, 32'h11223344); tick();
    idle();
    set_b(1'b1, 1'b0, 4'h0, 4'd3, 32'h0); tick();
    idle();
    repeat (1 + OUTREG) tick();
    chk1("t2_rvalid", b_rvalid, 1'b1);
    chk32("t2_rdata", b_rdata, 32'hAA22CC44);
    tick();

    // Write-write collision: B stalls one cycle and wins.
    set_a(1'b1, 1'b1, 4'hF, 4'd5, 32'h1);
    set_b(1'b1, 1'b1, 4'hF, 4'd5, 32'h2);
    tick();
    set_a(1'b0, 1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    idle();
    set_a(1'b1, 1'b0, 4'h0, 4'd5, 32'h0); tick();
    idle();
    repeat (1 + OUTREG) tick();
    chk32("t3_rdata", a_rdata, 32'h2);

    // Mixed-port read-during-write returns old data.
    set_a(1'b1, 1'b1, 4'hF, 4'd7, 32'h55);
    set_b(1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
    tick();
    idle();
    set_b(1'b1, 1'b0, 4'h0, 4'd7, 32'h0);
    tick();
    idle();
    repeat (OUTREG) tick();
    chk32("t4_old", b_rdata, 32'h0);
    tick();
    chk32("t4_new", b_rdata, 32'h55);
    tick();

    // Reset with reads in flight.
    set_a(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    set_b(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
    tick();
    tick();
    idle();
    do_reset();
    repeat (16) tick();
    set_a(1'b1, 1'b0, 4'h0, 4'd3, 32'h0);
    set_b(1'b1, 1'b0, 4'h0, 4'd5, 32'h0);
    tick();
    idle();
    repeat (1 + OUTREG) tick();
    chk1("t5_rvalid", a_rvalid, 1'b1);
    chk32("t5_a_cleared", a_rdata, 32'h0);
    chk32("t5_b_cleared", b_rdata, 32'h0);

    // Random traffic with addresses clustered to provoke collisions.
    for (int k = 0; k < 300; k++) begin
      set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
            4'($urandom_range(0, 3)), $urandom);
      set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
            4'($urandom_range(0, 3)), $urandom);
      tick();
    end
    idle();
    repeat (3) tick();

    // Streaming reads: continuous rvalid on both ports.
    run_a = 0;
    run_b = 0;
    for (int i = 0; i < 18 + int'(OUTREG); i++) begin
      if (i < 16) begin
        set_a(1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
        set_b(1'b1, 1'b0, 4'h0, 4'(i), 32'h0);
      end else begin
        idle();
      end
      tick();
      if (a_rvalid) run_a++;
      if (b_rvalid) run_b++;
    end
    chk32("t6_run_a", 32'(run_a), 32'd16);
    chk32("t6_run_b", 32'(run_b), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
